// File: rtl/pll_lock_sequencer.sv
// Purpose : power-up / lock-loss sequencer for the UART PLL, running on the board reference clock.
// Latency : outputs are registered from next-state; sys_rst releases RST_CYCLES+STABLE_CYCLES+1 edges after rst with lock held.
// Backpr. : none; pll_locked is resynchronised, relock_req is a single-cycle request sampled every edge.
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 16
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       sys_ready,
    output logic       lock_fail,
    output logic [1:0] retry_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_LOST      = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    // Terminal counts for each timed state; the counter starts at 0 on entry.
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRY);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    logic             sync1_q;
    logic             lock_s_q;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             sys_ready_q, sys_ready_d;
    logic             lock_fail_q, lock_fail_d;

    // Two-flop synchroniser for the asynchronous PLL lock flag.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= pll_locked;
            lock_s_q <= sync1_q;
        end
    end

    // State, shared counter, retry count and registered outputs.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= S_PLL_RST;
            cnt_q       <= '0;
            retry_q     <= 2'd0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            sys_ready_q <= 1'b0;
            lock_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_q   <= sys_rst_d;
            sys_ready_q <= sys_ready_d;
            lock_fail_q <= lock_fail_d;
        end
    end

    // Next-state, retry bookkeeping, counter and output decode from the next state.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;

        case (state_q)
            S_PLL_RST: begin
                // relock_req is deliberately ignored: the PLL is already being reset.
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                // Request beats lock, and lock beats the timeout in the same cycle.
                if (relock_req) begin
                    state_d = S_PLL_RST;
                end else if (lock_s_q) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = S_FAIL;
                    end else begin
                        retry_d = retry_q + 2'd1;
                        state_d = S_PLL_RST;
                    end
                end
            end
            S_STABLE: begin
                // A lock dropout restarts the lock wait without charging a retry.
                if (relock_req) begin
                    state_d = S_PLL_RST;
                end else if (!lock_s_q) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (relock_req) begin
                    state_d = S_PLL_RST;
                end else if (!lock_s_q) begin
                    state_d = S_LOST;
                end
            end
            S_LOST: begin
                // Single cycle with downstream held in reset before the PLL is reset.
                state_d = S_PLL_RST;
            end
            S_FAIL: begin
                if (relock_req) begin
                    state_d = S_PLL_RST;
                    retry_d = 2'd0;
                end
            end
            default: begin
                state_d = S_PLL_RST;
            end
        endcase

        // A successful bring-up forgives earlier timeouts.
        if ((state_d == S_RUN) && (state_q != S_RUN)) begin
            retry_d = 2'd0;
        end

        // Counter restarts on any transition; it saturates in the untimed
        // states (RUN, FAIL) so a long dwell can never alias a terminal count.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        pll_rst_d   = (state_d == S_PLL_RST) || (state_d == S_FAIL);
        sys_rst_d   = (state_d != S_RUN);
        sys_ready_d = (state_d == S_RUN);
        lock_fail_d = (state_d == S_FAIL);
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign sys_ready = sys_ready_q;
    assign lock_fail = lock_fail_q;
    assign retry_cnt = retry_q;
    assign state     = state_q;

endmodule
